nmi_arbiter: RTL and testbench



---
 rtl/nmi_arb_pkg.sv | 10 +
 rtl/nmi_arbiter_if.sv | 27 ++
 rtl/nmi_arb_pick.sv | 22 ++
 rtl/nmi_arbiter.sv | 67 ++++++
 tb/tb_nmi_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nmi_arb_pkg.sv
// nmi_arb_pkg: FSM states, arbitration modes, error fill and index-width helper for the NMI arbiter
package nmi_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  localparam int ARB_RR = 0;
  localparam int ARB_FIXED = 1;
  localparam logic ERR_FILL = 1'b1;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/nmi_arbiter_if.sv
// nmi_arbiter_if: packed per-master request/completion lanes plus the shared downstream NMI port
interface nmi_arbiter_if #(
  parameter int NUM_MST = 4,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [NUM_MST-1:0] m_valid_i;
  logic [NUM_MST*AW-1:0] m_addr_i;
  logic [NUM_MST*DW-1:0] m_wdata_i;
  logic [NUM_MST*DW/8-1:0] m_wstrb_i;
  logic [NUM_MST-1:0] m_ready_o;
  logic [NUM_MST*DW-1:0] m_rdata_o;
  logic s_valid_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_wdata_o;
  logic [DW/8-1:0] s_wstrb_o;
  logic s_ready_i;
  logic [DW-1:0] s_rdata_i;
  modport master (
    input m_valid_i, m_addr_i, m_wdata_i, m_wstrb_i, s_ready_i, s_rdata_i,
    output m_ready_o, m_rdata_o, s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o
  );
  modport slave (
    output m_valid_i, m_addr_i, m_wdata_i, m_wstrb_i, s_ready_i, s_rdata_i,
    input m_ready_o, m_rdata_o, s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o
  );
endinterface

// File: rtl/nmi_arb_pick.sv
// nmi_arb_pick: combinational winner select, round-robin from ptr (mode 0) or lowest index (mode 1)
module nmi_arb_pick
  import nmi_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] base;
  assign base = mode ? '0 : ptr;
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(base) + i) % N]) idx = IW'((int'(base) + i) % N);
  end
  assign win = |req ? N'(1) << idx : '0;
endmodule

// File: rtl/nmi_arbiter.sv
// nmi_arbiter: N-master NMI arbiter (round-robin/fixed priority), NMI_ARB_TIMEOUT_EN adds a hung-transfer watchdog
module nmi_arbiter
  import nmi_arb_pkg::*;
#(
  parameter int NUM_MST = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int ARB_MODE = ARB_RR,
  parameter int TIMEOUT_CYC = 255,
  localparam int IW = idx_w(NUM_MST)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  nmi_arbiter_if.master      bus,
  output logic [NUM_MST-1:0] grant_o,
  output logic               timeout_o
);
  arb_state_t state;
  logic [IW-1:0] ptr, g, pick_idx;
  logic [NUM_MST-1:0] pick_win;
  logic busy, req_g, done, to, fin;
  nmi_arb_pick #(.N(NUM_MST)) u_pick (
    .req(bus.m_valid_i),
    .ptr(ptr),
    .mode(ARB_MODE == ARB_FIXED),
    .win(pick_win),
    .idx(pick_idx)
  );
  assign busy = state == ARB_BUSY;
  assign req_g = busy & bus.m_valid_i[g];
  assign done = req_g & bus.s_ready_i;
`ifdef NMI_ARB_TIMEOUT_EN
  logic [15:0] cnt;
  assign to = req_g & ~bus.s_ready_i & (cnt == 16'(TIMEOUT_CYC));
  always_ff @(posedge clk_i)
    cnt <= (rst_i || !req_g || fin) ? '0 : cnt + 16'd1;
`else
  assign to = 1'b0;
`endif
  assign fin = done | to;
  assign timeout_o = to;
  assign bus.s_valid_o = req_g & ~to;
  assign bus.s_addr_o = busy ? bus.m_addr_i[int'(g)*AW +: AW] : '0;
  assign bus.s_wdata_o = busy ? bus.m_wdata_i[int'(g)*DW +: DW] : '0;
  assign bus.s_wstrb_o = busy ? bus.m_wstrb_i[int'(g)*(DW/8) +: DW/8] : '0;
  assign bus.m_ready_o = fin ? grant_o : '0;
  for (genvar k = 0; k < NUM_MST; k++) begin : g_rd
    assign bus.m_rdata_o[k*DW +: DW] = (fin & grant_o[k]) ? (to ? {DW{ERR_FILL}} : bus.s_rdata_i) : '0;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= ARB_IDLE;
      ptr <= '0;
      g <= '0;
      grant_o <= '0;
    end else if (!busy) begin
      if (|bus.m_valid_i) begin
        state <= ARB_BUSY;
        g <= pick_idx;
        grant_o <= pick_win;
      end
    end else if (!req_g || fin) begin
      state <= ARB_IDLE;
      grant_o <= '0;
      if (fin) ptr <= (g == IW'(NUM_MST - 1)) ? '0 : g + IW'(1);
    end
endmodule

// File: tb/tb_nmi_arbiter.sv
// tb_nmi_arbiter: directed vectors, corner sequences and randomized traffic against a reference model
module tb_nmi_arbiter;
  localparam int N = 4, AW = 32, DW = 32, TO = 8;
`ifdef NMI_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  typedef struct {
    logic [N-1:0] grant, ready;
    logic [N*DW-1:0] rdata;
    logic s_valid;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic to;
  } out_t;
  typedef struct {
    int d;
    logic [N-1:0] v;
    logic rdy;
    logic [N-1:0] g, r;
    logic sv;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] valid [2];
  logic [N*AW-1:0] addr [2];
  logic [N*DW-1:0] wdata [2];
  logic [N*DW/8-1:0] wstrb [2];
  logic s_ready [2];
  logic [DW-1:0] s_rdata [2];
  logic [N-1:0] grant0, grant1;
  logic to0, to1;
  nmi_arbiter_if #(.NUM_MST(N), .AW(AW), .DW(DW)) bus0 ();
  nmi_arbiter_if #(.NUM_MST(N), .AW(AW), .DW(DW)) bus1 ();
  assign bus0.m_valid_i = valid[0];
  assign bus0.m_addr_i = addr[0];
  assign bus0.m_wdata_i = wdata[0];
  assign bus0.m_wstrb_i = wstrb[0];
  assign bus0.s_ready_i = s_ready[0];
  assign bus0.s_rdata_i = s_rdata[0];
  assign bus1.m_valid_i = valid[1];
  assign bus1.m_addr_i = addr[1];
  assign bus1.m_wdata_i = wdata[1];
  assign bus1.m_wstrb_i = wstrb[1];
  assign bus1.s_ready_i = s_ready[1];
  assign bus1.s_rdata_i = s_rdata[1];
  nmi_arbiter #(.NUM_MST(N), .AW(AW), .DW(DW), .ARB_MODE(0), .TIMEOUT_CYC(TO)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0.master), .grant_o(grant0), .timeout_o(to0)
  );
  nmi_arbiter #(.NUM_MST(N), .AW(AW), .DW(DW), .ARB_MODE(1), .TIMEOUT_CYC(TO)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1.master), .grant_o(grant1), .timeout_o(to1)
  );
  int n_chk = 0, n_fail = 0;
  bit busy [2];
  int own [2], ptr [2], cnt [2];
  logic [N-1:0] exp_ready [2];
  bit pend [2][N];
  vec_t tbl [$];
  out_t a;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input int d, input logic [N-1:0] v, input logic rdy, input logic [N-1:0] g, input logic [N-1:0] r, input logic sv);
    vec_t x;
    x.d = d; x.v = v; x.rdy = rdy; x.g = g; x.r = r; x.sv = sv;
    return x;
  endfunction
  function automatic int pick(input int d, input logic [N-1:0] v);
    int j;
    for (int i = 0; i < N; i++) begin
      j = (d == 1) ? i : (ptr[d] + i) % N;
      if (v[j]) return j;
    end
    return 0;
  endfunction
  function automatic out_t model_out(input int d);
    out_t o;
    logic v, ok, t;
    o.grant = '0; o.ready = '0; o.rdata = '0; o.s_valid = 1'b0;
    o.s_addr = '0; o.s_wdata = '0; o.s_wstrb = '0; o.to = 1'b0;
    if (busy[d]) begin
      v = valid[d][own[d]];
      ok = v && s_ready[d];
      t = TO_EN && v && !s_ready[d] && cnt[d] == TO;
      o.grant = N'(1) << own[d];
      o.ready = (ok || t) ? o.grant : '0;
      o.rdata[own[d]*DW +: DW] = ok ? s_rdata[d] : t ? '1 : '0;
      o.s_valid = v && !t;
      o.s_addr = addr[d][own[d]*AW +: AW];
      o.s_wdata = wdata[d][own[d]*DW +: DW];
      o.s_wstrb = wstrb[d][own[d]*(DW/8) +: DW/8];
      o.to = t;
    end
    return o;
  endfunction
  function automatic out_t observe(input int d);
    out_t o;
    if (d == 0) begin
      o.grant = grant0; o.ready = bus0.m_ready_o; o.rdata = bus0.m_rdata_o; o.s_valid = bus0.s_valid_o;
      o.s_addr = bus0.s_addr_o; o.s_wdata = bus0.s_wdata_o; o.s_wstrb = bus0.s_wstrb_o; o.to = to0;
    end else begin
      o.grant = grant1; o.ready = bus1.m_ready_o; o.rdata = bus1.m_rdata_o; o.s_valid = bus1.s_valid_o;
      o.s_addr = bus1.s_addr_o; o.s_wdata = bus1.s_wdata_o; o.s_wstrb = bus1.s_wstrb_o; o.to = to1;
    end
    return o;
  endfunction
  task automatic check_dut(input int d);
    out_t e, o;
    string p;
    e = model_out(d);
    o = observe(d);
    p = d == 0 ? "rr" : "fp";
    chk({p, ".grant"}, 128'(o.grant), 128'(e.grant));
    chk({p, ".m_ready"}, 128'(o.ready), 128'(e.ready));
    chk({p, ".m_rdata"}, 128'(o.rdata), 128'(e.rdata));
    chk({p, ".s_valid"}, 128'(o.s_valid), 128'(e.s_valid));
    chk({p, ".s_addr"}, 128'(o.s_addr), 128'(e.s_addr));
    chk({p, ".s_wdata"}, 128'(o.s_wdata), 128'(e.s_wdata));
    chk({p, ".s_wstrb"}, 128'(o.s_wstrb), 128'(e.s_wstrb));
    chk({p, ".timeout"}, 128'(o.to), 128'(e.to));
    exp_ready[d] = e.ready;
  endtask
  task automatic model_step(input int d);
    out_t e;
    if (rst) begin
      busy[d] = 1'b0; ptr[d] = 0; cnt[d] = 0; own[d] = 0;
    end else if (!busy[d]) begin
      if (|valid[d]) begin
        busy[d] = 1'b1; own[d] = pick(d, valid[d]); cnt[d] = 0;
      end
    end else begin
      e = model_out(d);
      if (!valid[d][own[d]]) busy[d] = 1'b0;
      else if (e.ready != '0) begin
        busy[d] = 1'b0; ptr[d] = (own[d] + 1) % N;
      end else cnt[d]++;
    end
  endtask
  task automatic settle();
    @(negedge clk);
  endtask
  task automatic step();
    check_dut(0);
    check_dut(1);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl.push_back(mk(0, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk(0, 4'hF, 1'b1, 4'h1, 4'h1, 1'b1));
    tbl.push_back(mk(0, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk(0, 4'hF, 1'b1, 4'h2, 4'h2, 1'b1));
    tbl.push_back(mk(0, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk(0, 4'hF, 1'b1, 4'h4, 4'h4, 1'b1));
    tbl.push_back(mk(0, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk(0, 4'hF, 1'b1, 4'h8, 4'h8, 1'b1));
    tbl.push_back(mk(0, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk(0, 4'hF, 1'b1, 4'h1, 4'h1, 1'b1));
    tbl.push_back(mk(0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk(1, 4'hA, 1'b1, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk(1, 4'hA, 1'b1, 4'h2, 4'h2, 1'b1));
    tbl.push_back(mk(1, 4'hA, 1'b1, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk(1, 4'hA, 1'b1, 4'h2, 4'h2, 1'b1));
    tbl.push_back(mk(1, 4'hA, 1'b1, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk(1, 4'hA, 1'b1, 4'h2, 4'h2, 1'b1));
    tbl.push_back(mk(1, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0));
    for (int d = 0; d < 2; d++) begin
      valid[d] = '0; s_ready[d] = 1'b0; s_rdata[d] = '0; wstrb[d] = '0;
      busy[d] = 1'b0; own[d] = 0; ptr[d] = 0; cnt[d] = 0; exp_ready[d] = '0;
      for (int k = 0; k < N; k++) begin
        addr[d][k*AW +: AW] = AW'(32'h3000_0000 + k * 256);
        wdata[d][k*DW +: DW] = DW'(32'hD000_0000 + k);
        pend[d][k] = 1'b0;
      end
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
    chk("reset.grant_rr", 128'(grant0), 128'(0));
    chk("reset.grant_fp", 128'(grant1), 128'(0));
    chk("reset.m_ready", 128'(bus0.m_ready_o), 128'(0));
    chk("reset.m_rdata", 128'(bus0.m_rdata_o), 128'(0));
    chk("reset.s_valid", 128'(bus0.s_valid_o), 128'(0));
    chk("reset.s_addr", 128'(bus0.s_addr_o), 128'(0));
    chk("reset.timeout", 128'(to0), 128'(0));
    step();
    foreach (tbl[i]) begin
      valid[tbl[i].d] = tbl[i].v;
      valid[1 - tbl[i].d] = '0;
      s_ready[0] = tbl[i].rdy;
      s_ready[1] = tbl[i].rdy;
      s_rdata[0] = $urandom;
      s_rdata[1] = $urandom;
      settle();
      a = observe(tbl[i].d);
      chk($sformatf("vec%0d.grant", i), 128'(a.grant), 128'(tbl[i].g));
      chk($sformatf("vec%0d.m_ready", i), 128'(a.ready), 128'(tbl[i].r));
      chk($sformatf("vec%0d.s_valid", i), 128'(a.s_valid), 128'(tbl[i].sv));
      step();
    end
    s_ready[0] = 1'b0;
    s_ready[1] = 1'b0;
    valid[0] = 4'b0100;
    addr[0][2*AW +: AW] = 32'h3000_0010;
    settle();
    chk("rd.idle_grant", 128'(grant0), 128'(0));
    step();
    settle();
    chk("rd.grant", 128'(grant0), 128'(4));
    chk("rd.s_valid", 128'(bus0.s_valid_o), 128'(1));
    chk("rd.s_addr", 128'(bus0.s_addr_o), 128'(32'h3000_0010));
    chk("rd.s_wstrb", 128'(bus0.s_wstrb_o), 128'(0));
    step();
    settle();
    chk("rd.wait_ready", 128'(bus0.m_ready_o), 128'(0));
    step();
    s_ready[0] = 1'b1;
    s_rdata[0] = 32'h1234_5678;
    settle();
    chk("rd.m_ready", 128'(bus0.m_ready_o), 128'(4));
    chk("rd.m_rdata", 128'(bus0.m_rdata_o), 128'h0000_0000_1234_5678_0000_0000_0000_0000);
    step();
    valid[0] = '0;
    s_ready[0] = 1'b0;
    settle();
    chk("rd.grant_after", 128'(grant0), 128'(0));
    step();
    valid[0] = 4'b0010;
    wstrb[0][4 +: 4] = 4'hF;
    settle();
    step();
    settle();
    chk("rst.grant", 128'(grant0), 128'(2));
    chk("rst.s_wstrb", 128'(bus0.s_wstrb_o), 128'(4'hF));
    step();
    repeat (2) begin
      settle();
      step();
    end
    rst = 1'b1;
    settle();
    step();
    rst = 1'b0;
    valid[0] = 4'hF;
    settle();
    chk("rst.grant_cleared", 128'(grant0), 128'(0));
    chk("rst.no_ready", 128'(bus0.m_ready_o), 128'(0));
    chk("rst.s_valid", 128'(bus0.s_valid_o), 128'(0));
    chk("rst.s_wstrb", 128'(bus0.s_wstrb_o), 128'(0));
    step();
    s_ready[0] = 1'b1;
    settle();
    chk("rst.ptr0_grant", 128'(grant0), 128'(1));
    chk("rst.ptr0_ready", 128'(bus0.m_ready_o), 128'(1));
    step();
    valid[0] = '0;
    s_ready[0] = 1'b0;
    settle();
    step();
`ifdef NMI_ARB_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      valid[0] = 4'b0001;
      s_ready[0] = 1'b0;
      settle();
      step();
      for (int b = 1; b <= TO; b++) begin
        settle();
        chk($sformatf("to%0d.early_b%0d", r, b), 128'({to0, bus0.m_ready_o}), 128'(0));
        step();
      end
      s_ready[0] = (r == 1);
      s_rdata[0] = 32'hA5A5_0001;
      settle();
      chk($sformatf("to%0d.m_ready", r), 128'(bus0.m_ready_o), 128'(1));
      chk($sformatf("to%0d.timeout", r), 128'(to0), 128'(r == 0));
      chk($sformatf("to%0d.s_valid", r), 128'(bus0.s_valid_o), 128'(r == 1));
      chk($sformatf("to%0d.m_rdata", r), 128'(bus0.m_rdata_o), r == 0 ? 128'hFFFF_FFFF : 128'hA5A5_0001);
      step();
      valid[0] = '0;
      s_ready[0] = 1'b0;
      settle();
      step();
    end
`else
    valid[0] = 4'b0001;
    s_ready[0] = 1'b0;
    for (int b = 0; b < 20; b++) begin
      settle();
      if (b > 0) chk($sformatf("hang.b%0d", b), 128'({to0, bus0.m_ready_o, bus0.s_valid_o}), 128'(1));
      step();
    end
    s_ready[0] = 1'b1;
    settle();
    chk("hang.release", 128'(bus0.m_ready_o), 128'(1));
    step();
    valid[0] = '0;
    s_ready[0] = 1'b0;
    settle();
    step();
`endif
    for (int c = 0; c < 1200; c++) begin
      rst = ($urandom_range(299) == 0);
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < N; k++) begin
          if (pend[d][k] && (exp_ready[d][k] || $urandom_range(63) == 0)) pend[d][k] = 1'b0;
          else if (!pend[d][k] && $urandom_range(2) == 0) begin
            pend[d][k] = 1'b1;
            addr[d][k*AW +: AW] = $urandom;
            wdata[d][k*DW +: DW] = $urandom;
            wstrb[d][k*(DW/8) +: DW/8] = 4'($urandom);
          end
          valid[d][k] = pend[d][k];
        end
        s_ready[d] = ($urandom_range(2) == 0);
        s_rdata[d] = $urandom;
      end
      settle();
      step();
    end
    rst = 1'b0;
    valid[0] = '0;
    valid[1] = '0;
    repeat (3) begin
      settle();
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
